// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Holds one instruction, waits for the data-SRAM response of loads/stores,
// aligns and extends sub-word load data, and hands the result to WB.
// Responses orphaned by a WB flush are counted and dropped on arrival.
// Optional feature macro: MS_SUBWORD_LOAD_EN (b/h/bu/hu extraction).
// Without it every load returns the full read word and es_ld_op is ignored.
//
// Handshake: a transfer EX->MS happens in a cycle with es_to_ms_valid &
// ms_allowin; a transfer MS->WB happens in a cycle with ms_to_ws_valid &
// ws_allowin. Valid is never conditioned on the consumer's allowin.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [4:0]  es_dest,
  input  logic        es_gr_we,
  input  logic        es_res_from_mem,
  input  logic [2:0]  es_ld_op,
  input  logic [31:0] es_alu_result,
  input  logic        es_excp,
  input  logic [15:0] es_excp_num,
  input  logic        es_ertn,
  input  logic        es_req_sent,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        wb_flush,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [4:0]  ms_dest,
  output logic        ms_gr_we,
  output logic [31:0] ms_final_result,
  output logic        ms_excp,
  output logic [15:0] ms_excp_num,
  output logic        ms_ertn,
  output logic        ms_ex,
  output logic [39:0] ms_forward,
  output logic [3:0]  ms_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic        ms_valid;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  cancel_cnt;
  logic [31:0] data_buf;
  logic        res_from_mem_r;
  logic [31:0] alu_result_r;
  logic        req_sent_r;
  logic        need_data;
  logic        own_ok;
  logic        ms_ready_go;
  logic        ms_data_pending;
  logic        entry;
  logic        cancel_inc;
  logic        cancel_dec;
  logic [31:0] load_word;
  logic [31:0] extracted;

  // A response is ours only when no orphaned response is still in flight.
  assign need_data       = ms_valid & req_sent_r & ~ms_excp;
  assign own_ok          = (state == ST_WAIT) & data_sram_data_ok & (cancel_cnt == 2'd0);
  assign ms_ready_go     = ~need_data | own_ok | (state == ST_HOLD);
  assign ms_to_ws_valid  = ms_valid & ms_ready_go & ~wb_flush;
  assign ms_allowin      = ~ms_valid | (ms_ready_go & ws_allowin);
  assign entry           = es_to_ms_valid & ms_allowin;
  assign ms_data_pending = ms_valid & need_data & ~ms_ready_go;
  assign ms_ex           = ms_valid & (ms_excp | ms_ertn);
  assign ms_forward      = {ms_valid, ms_gr_we, ms_data_pending, ms_dest, ms_final_result};
  assign ms_dbg          = {cancel_cnt, state};

  // Valid bit: flush wins over a same-cycle entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ms_valid <= 1'b0;
    else if (wb_flush) ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= es_to_ms_valid;
  end

  // Payload capture on EX->MS transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_pc          <= 32'd0;
      ms_dest        <= 5'd0;
      ms_gr_we       <= 1'b0;
      res_from_mem_r <= 1'b0;
      alu_result_r   <= 32'd0;
      ms_excp        <= 1'b0;
      ms_excp_num    <= 16'd0;
      ms_ertn        <= 1'b0;
      req_sent_r     <= 1'b0;
    end else if (entry) begin
      ms_pc          <= es_pc;
      ms_dest        <= es_dest;
      ms_gr_we       <= es_gr_we;
      res_from_mem_r <= es_res_from_mem;
      alu_result_r   <= es_alu_result;
      ms_excp        <= es_excp;
      ms_excp_num    <= es_excp_num;
      ms_ertn        <= es_ertn;
      req_sent_r     <= es_req_sent;
    end
  end

  // Wait-state next-state: an outgoing handoff may be followed by a new owed response.
  always_comb begin
    state_nxt = state;
    if (wb_flush) state_nxt = ST_IDLE;
    else if (ms_allowin) state_nxt = (entry & es_req_sent & ~es_excp) ? ST_WAIT : ST_IDLE;
    else if (own_ok) state_nxt = ST_HOLD;
  end

  // Wait-state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // Keep the response while WB stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) data_buf <= 32'd0;
    else if (own_ok) data_buf <= data_sram_rdata;
  end

  // Orphan counter: +1 for a flushed owed response, -1 for each dropped response.
  assign cancel_inc = wb_flush & (state == ST_WAIT) & ~own_ok;
  assign cancel_dec = data_sram_data_ok & (cancel_cnt != 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cancel_cnt <= 2'd0;
    else if (cancel_inc & ~cancel_dec & (cancel_cnt != 2'd3)) cancel_cnt <= cancel_cnt + 2'd1;
    else if (cancel_dec & ~cancel_inc) cancel_cnt <= cancel_cnt - 2'd1;
  end

  assign load_word = (state == ST_HOLD) ? data_buf : data_sram_rdata;

`ifdef MS_SUBWORD_LOAD_EN
  logic [2:0]  ld_op_r;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load type travels with the instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ld_op_r <= 3'd0;
    else if (entry) ld_op_r <= es_ld_op;
  end

  // Pick the addressed lane and sign/zero-extend it.
  always_comb begin
    case (alu_result_r[1:0])
      2'b00:   ld_byte = load_word[7:0];
      2'b01:   ld_byte = load_word[15:8];
      2'b10:   ld_byte = load_word[23:16];
      default: ld_byte = load_word[31:24];
    endcase
    ld_half = alu_result_r[1] ? load_word[31:16] : load_word[15:0];
    case (ld_op_r)
      3'b001:  extracted = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  extracted = {{16{ld_half[15]}}, ld_half};
      3'b011:  extracted = {24'd0, ld_byte};
      3'b100:  extracted = {16'd0, ld_half};
      default: extracted = load_word;
    endcase
  end
`else
  logic unused_ld_op;
  assign unused_ld_op = ^es_ld_op;
  assign extracted    = load_word;
`endif

  assign ms_final_result = res_from_mem_r ? extracted : alu_result_r;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_res_from_mem;
  logic [2:0]  es_ld_op;
  logic [31:0] es_alu_result;
  logic        es_excp;
  logic [15:0] es_excp_num;
  logic        es_ertn;
  logic        es_req_sent;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        wb_flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic [31:0] ms_final_result;
  logic        ms_excp;
  logic [15:0] ms_excp_num;
  logic        ms_ertn;
  logic        ms_ex;
  logic [39:0] ms_forward;
  logic [3:0]  ms_dbg;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_dest(es_dest), .es_gr_we(es_gr_we),
    .es_res_from_mem(es_res_from_mem), .es_ld_op(es_ld_op),
    .es_alu_result(es_alu_result), .es_excp(es_excp), .es_excp_num(es_excp_num),
    .es_ertn(es_ertn), .es_req_sent(es_req_sent),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .wb_flush(wb_flush),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_dest(ms_dest),
    .ms_gr_we(ms_gr_we), .ms_final_result(ms_final_result), .ms_excp(ms_excp),
    .ms_excp_num(ms_excp_num), .ms_ertn(ms_ertn), .ms_ex(ms_ex),
    .ms_forward(ms_forward), .ms_dbg(ms_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the instruction held in MS and the outstanding orphan count.
  logic        m_valid, m_gr_we, m_mem, m_excp, m_ertn, m_req, m_have;
  logic [31:0] m_pc, m_alu, m_data;
  logic [4:0]  m_dest;
  logic [2:0]  m_op;
  logic [15:0] m_excpn;
  int          m_orph;
  // Memory model: due cycles of outstanding responses, served in order.
  int          due_q[$];
  int          cyc_n = 0;

  function automatic logic [31:0] ref_extract(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [2:0] op);
    logic [31:0] b, h, r;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd1:    r = b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd2:    r = h[15] ? (h | 32'hFFFF_0000) : h;
      3'd3:    r = b;
      3'd4:    r = h;
      default: r = word;
    endcase
`ifdef MS_SUBWORD_LOAD_EN
    return r;
`else
    return (r == r) ? word : word;
`endif
  endfunction

  task automatic reset_model();
    m_valid = 0; m_have = 0; m_orph = 0; m_req = 0; m_excp = 0; m_ertn = 0;
    m_mem = 0; m_gr_we = 0; m_pc = 0; m_alu = 0; m_data = 0; m_dest = 0;
    m_op = 0; m_excpn = 0;
    due_q.delete();
  endtask

  // Compare all outputs for the current cycle, then advance the model.
  task automatic eval_cycle();
    logic need, own_ok, ready, e_allow, e_out, pend;
    logic [31:0] e_res;
    int lat, due;
    #1;
    need    = m_valid & m_req & ~m_excp;
    own_ok  = need & ~m_have & data_sram_data_ok & (m_orph == 0);
    ready   = ~need | m_have | own_ok;
    e_out   = m_valid & ready & ~wb_flush;
    e_allow = ~m_valid | (ready & ws_allowin);
    pend    = m_valid & need & ~ready;
    e_res   = m_mem ? ref_extract(m_have ? m_data : data_sram_rdata, m_alu, m_op) : m_alu;
    check("allowin", ms_allowin, e_allow);
    check("to_ws_valid", ms_to_ws_valid, e_out);
    check("ms_ex", ms_ex, m_valid & (m_excp | m_ertn));
    check("fwd_valid", ms_forward[39], m_valid);
    check("fwd_pending", ms_forward[37], pend);
    check("cancel_cnt", ms_dbg[3:2], m_orph[1:0]);
    if (m_valid) begin
      check("pc", ms_pc, m_pc);
      check("dest", ms_dest, m_dest);
      check("fwd_dest", ms_forward[36:32], m_dest);
      check("gr_we", ms_gr_we, m_gr_we);
      check("fwd_gr_we", ms_forward[38], m_gr_we);
      check("excp", ms_excp, m_excp);
      check("excp_num", ms_excp_num, m_excpn);
      check("ertn", ms_ertn, m_ertn);
      if (ready) begin
        check("result", ms_final_result, e_res);
        check("fwd_result", ms_forward[31:0], e_res);
      end
    end
    // advance model
    if (data_sram_data_ok && due_q.size() > 0) void'(due_q.pop_front());
    if (data_sram_data_ok && m_orph > 0) m_orph--;
    if (wb_flush && need && !m_have && !own_ok && m_orph < 3) m_orph++;
    if (own_ok) begin m_have = 1; m_data = data_sram_rdata; end
    if (es_to_ms_valid && e_allow) begin
      m_pc = es_pc; m_dest = es_dest; m_gr_we = es_gr_we; m_mem = es_res_from_mem;
      m_op = es_ld_op; m_alu = es_alu_result; m_excp = es_excp; m_excpn = es_excp_num;
      m_ertn = es_ertn; m_req = es_req_sent;
      if (es_req_sent) begin
        lat = $urandom_range(1, 4);
        due = cyc_n + lat;
        if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
        due_q.push_back(due);
      end
    end
    if (wb_flush) begin m_valid = 0; m_have = 0; end
    else if (e_allow) begin m_valid = es_to_ms_valid; m_have = 0; end
    cyc_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    eval_cycle();
    tick();
  endtask

  // Driver tasks
  task automatic ex_send(input logic [31:0] pc, input logic mem, input logic [2:0] op,
                         input logic [31:0] addr, input logic req, input logic excp,
                         input logic [15:0] excpn);
    es_to_ms_valid = 1; es_pc = pc; es_dest = pc[6:2]; es_gr_we = 1;
    es_res_from_mem = mem; es_ld_op = op; es_alu_result = addr;
    es_req_sent = req; es_excp = excp; es_excp_num = excpn; es_ertn = 0;
  endtask

  task automatic ex_idle();
    es_to_ms_valid = 0; es_req_sent = 0; es_excp = 0; es_excp_num = 0; es_ertn = 0;
  endtask

  logic [31:0] exp_b, exp_bu, exp_h;

  initial begin
`ifdef MS_SUBWORD_LOAD_EN
    exp_b = 32'hFFFF_FF80; exp_bu = 32'h0000_0080; exp_h = 32'h0000_7FFF;
`else
    exp_b = 32'h80FF_FFFF; exp_bu = 32'h80FF_FFFF; exp_h = 32'h7FFF_0000;
`endif
    resetn = 0; ex_idle(); es_pc = 0; es_dest = 0; es_gr_we = 0; es_res_from_mem = 0;
    es_ld_op = 0; es_alu_result = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    ws_allowin = 1; wb_flush = 0;
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    check("rst_to_ws_valid", ms_to_ws_valid, 0);
    check("rst_allowin", ms_allowin, 1);
    check("rst_ms_ex", ms_ex, 0);
    check("rst_forward", ms_forward, 0);
    check("rst_dbg", ms_dbg, 0);
    @(negedge clk);
    resetn = 1;

    // ld.w at 0x100, response two cycles after entry
    ex_send(32'h1000, 1, 3'd0, 32'h100, 1, 0, 0); cyc();
    ex_idle(); eval_cycle(); check("t1_pending_a", ms_forward[37], 1); tick();
    eval_cycle(); check("t1_pending_b", ms_forward[37], 1); tick();
    data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678;
    eval_cycle(); check("t1_valid", ms_to_ws_valid, 1);
    check("t1_result", ms_final_result, 32'h1234_5678); tick();
    data_sram_data_ok = 0;

    // ld.b / ld.bu at low bits 2'b11
    ex_send(32'h1004, 1, 3'd1, 32'h203, 1, 0, 0); cyc();
    ex_idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_FFFF;
    eval_cycle(); check("t2_ldb", ms_final_result, exp_b); tick();
    data_sram_data_ok = 0;
    ex_send(32'h1008, 1, 3'd3, 32'h203, 1, 0, 0); cyc();
    ex_idle(); data_sram_data_ok = 1;
    eval_cycle(); check("t2_ldbu", ms_final_result, exp_bu); tick();
    data_sram_data_ok = 0;

    // response while WB stalls: buffered result survives later rdata changes
    ex_send(32'h100C, 1, 3'd0, 32'h300, 1, 0, 0); cyc();
    ex_idle(); ws_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D;
    eval_cycle(); check("t3_valid_ok", ms_to_ws_valid, 1); tick();
    data_sram_data_ok = 0;
    for (int i = 0; i < 2; i++) begin
      data_sram_rdata = $urandom;
      eval_cycle(); check("t3_hold_result", ms_final_result, 32'hCAFE_F00D); tick();
    end
    ws_allowin = 1;
    eval_cycle(); check("t3_release", ms_final_result, 32'hCAFE_F00D);
    check("t3_release_valid", ms_to_ws_valid, 1); tick();

    // flush while waiting, then ld.h at 0x2 behind an orphaned response
    ex_send(32'h1010, 1, 3'd0, 32'h40, 1, 0, 0); cyc();
    ex_idle(); cyc();
    wb_flush = 1; cyc(); wb_flush = 0;
    eval_cycle(); check("t4_cnt_one", ms_dbg[3:2], 1); tick();
    ex_send(32'h1014, 1, 3'd2, 32'h2, 1, 0, 0); cyc();
    ex_idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hAAAA_5555;
    eval_cycle(); check("t4_drop", ms_to_ws_valid, 0); tick();
    data_sram_data_ok = 0;
    eval_cycle(); check("t4_cnt_zero", ms_dbg[3:2], 0); tick();
    data_sram_data_ok = 1; data_sram_rdata = 32'h7FFF_0000;
    eval_cycle(); check("t4_valid", ms_to_ws_valid, 1);
    check("t4_ldh", ms_final_result, exp_h); tick();
    data_sram_data_ok = 0;

    // ALU op carrying an exception passes without waiting
    ex_send(32'h1018, 0, 3'd0, 32'h55, 0, 1, 16'h0040); cyc();
    ex_idle();
    eval_cycle(); check("t5_valid", ms_to_ws_valid, 1); check("t5_ms_ex", ms_ex, 1);
    check("t5_vec", ms_excp_num, 16'h0040); tick();

    // asynchronous reset in the middle of a held load
    ex_send(32'h101C, 1, 3'd0, 32'h80, 1, 0, 0); cyc();
    ex_idle(); ws_allowin = 0; data_sram_data_ok = 1; cyc();
    data_sram_data_ok = 0; cyc();
    #2 resetn = 0;
    #1;
    check("t6_to_ws_valid", ms_to_ws_valid, 0);
    check("t6_allowin", ms_allowin, 1);
    check("t6_ms_ex", ms_ex, 0);
    check("t6_forward", ms_forward, 0);
    reset_model();
    @(negedge clk);
    resetn = 1; ws_allowin = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      es_to_ms_valid  = ($urandom_range(0, 2) != 0);
      es_pc           = $urandom;
      es_dest         = 5'($urandom);
      es_gr_we        = 1'($urandom);
      es_excp         = ($urandom_range(0, 9) == 0);
      es_excp_num     = es_excp ? 16'(1 << $urandom_range(0, 15)) : 16'd0;
      es_ertn         = ~es_excp & ($urandom_range(0, 19) == 0);
      es_res_from_mem = (kind == 1);
      es_ld_op        = 3'($urandom_range(0, 4));
      es_alu_result   = $urandom;
      wb_flush        = ($urandom_range(0, 24) == 0) && (m_orph < 2);
      es_req_sent     = (kind != 0) & ~es_excp & ~wb_flush;
      ws_allowin      = ($urandom_range(0, 3) != 0);
      data_sram_data_ok = (due_q.size() > 0) && (due_q[0] <= cyc_n);
      data_sram_rdata = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
